// File: rtl/layer4_fc_mac_sched.sv
// Layer4 fully-connected MAC sequencer: one shared 16x16 multiplier, bias + N_IN MACs per neuron,
// rescale/saturate, valid/ready result stream. Define LAYER4_FC_RELU_EN to clamp negative results to zero.
module layer4_fc_mac_sched #(
  parameter int N_IN  = 120,
  parameter int N_OUT = 84,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40,
  parameter int AW_A  = 7,
  parameter int AW_W  = 14,
  parameter int AW_O  = 7
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_idle,
  output logic              ap_done,
  output logic              ap_ready,
  output logic              act_ce,
  output logic [AW_A-1:0]   act_addr,
  input  logic [DW-1:0]     act_q,
  output logic              wt_ce,
  output logic [AW_W-1:0]   wt_addr,
  input  logic [DW-1:0]     wt_q,
  output logic              bias_ce,
  output logic [AW_O-1:0]   bias_addr,
  input  logic [DW-1:0]     bias_q,
  output logic [DW-1:0]     mul_a,
  output logic [DW-1:0]     mul_b,
  input  logic [2*DW-1:0]   mul_p,
  output logic [DW-1:0]     out_data,
  output logic [AW_O-1:0]   out_idx,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_OUT, S_DONE} state_t;

  localparam logic [AW_A-1:0] I_LAST  = AW_A'(N_IN - 1);
  localparam logic [AW_A-1:0] I_FIRST = AW_A'(1);
  localparam logic [AW_O-1:0] J_LAST  = AW_O'(N_OUT - 1);
  localparam logic [AW_W-1:0] W_STEP  = AW_W'(N_IN);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  state_t                   state, state_nx;
  logic [AW_O-1:0]          j;
  logic [AW_A-1:0]          i;
  logic [AW_W-1:0]          wbase;
  logic                     dcnt;
  logic signed [2*DW-1:0]   prod_r;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  shifted;
  logic [DW-1:0]            result;

  assign prod_ext = {{(ACC_W-2*DW){prod_r[2*DW-1]}}, prod_r};
  assign bias_ext = {{(ACC_W-DW){bias_q[DW-1]}}, bias_q};
  assign shifted  = acc >>> FRAC;

  always_comb begin
    if (shifted > SAT_MAX)      result = SAT_MAX[DW-1:0];
    else if (shifted < SAT_MIN) result = SAT_MIN[DW-1:0];
    else                        result = shifted[DW-1:0];
`ifdef LAYER4_FC_RELU_EN
    if (acc < 0) result = '0;
`endif
  end

  // The first MAC cycle loads the bias, pre-shifted so it shares the product's 2*FRAC fraction.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state  <= S_IDLE;
      j      <= '0;
      i      <= '0;
      wbase  <= '0;
      dcnt   <= 1'b0;
      prod_r <= '0;
      acc    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (ap_start) begin
          j     <= '0;
          wbase <= '0;
        end
        S_BIAS: i <= I_FIRST;
        S_MAC: begin
          i      <= i + AW_A'(1);
          dcnt   <= 1'b0;
          prod_r <= mul_p;
          if (i == I_FIRST) acc <= bias_ext <<< FRAC;
          else              acc <= acc + prod_ext;
        end
        S_DRAIN: begin
          dcnt <= 1'b1;
          if (!dcnt) prod_r <= mul_p;
          acc <= acc + prod_ext;
        end
        S_OUT: if (out_ready && j != J_LAST) begin
          j     <= j + AW_O'(1);
          wbase <= wbase + W_STEP;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    ap_idle   = 1'b0;
    ap_done   = 1'b0;
    ap_ready  = 1'b0;
    act_ce    = 1'b0;
    wt_ce     = 1'b0;
    bias_ce   = 1'b0;
    act_addr  = '0;
    wt_addr   = '0;
    bias_addr = '0;
    mul_a     = '0;
    mul_b     = '0;
    out_data  = '0;
    out_idx   = '0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) state_nx = S_BIAS;
      end
      S_BIAS: begin
        bias_ce   = 1'b1;
        bias_addr = j;
        act_ce    = 1'b1;
        wt_ce     = 1'b1;
        wt_addr   = wbase;
        state_nx  = S_MAC;
      end
      S_MAC: begin
        act_ce   = 1'b1;
        wt_ce    = 1'b1;
        act_addr = i;
        wt_addr  = wbase + AW_W'(i);
        mul_a    = act_q;
        mul_b    = wt_q;
        if (i == I_LAST) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (!dcnt) begin
          mul_a = act_q;
          mul_b = wt_q;
        end else begin
          state_nx = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_data  = result;
        out_idx   = j;
        if (out_ready) state_nx = (j == J_LAST) ? S_DONE : S_BIAS;
      end
      S_DONE: begin
        ap_done  = 1'b1;
        ap_ready = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_layer4_fc_mac_sched.sv
// Directed self-checking bench for layer4_fc_mac_sched at N_IN=4, N_OUT=2, FRAC=8.
module tb_layer4_fc_mac_sched;
  localparam int N_IN = 4, N_OUT = 2, DW = 16, FRAC = 8, ACC_W = 40;
  localparam int AW_A = 2, AW_W = 3, AW_O = 1;

`ifdef LAYER4_FC_RELU_EN
  localparam logic [15:0] EXP_NEG_B = 16'h0000;
  localparam logic [15:0] EXP_NEG_C = 16'h0000;
  localparam logic [15:0] EXP_NEG_D = 16'h0000;
`else
  localparam logic [15:0] EXP_NEG_B = 16'hFF00;
  localparam logic [15:0] EXP_NEG_C = 16'h8000;
  localparam logic [15:0] EXP_NEG_D = 16'hFE40;
`endif

  logic ap_clk = 1'b0;
  logic ap_rst_n, ap_start, ap_idle, ap_done, ap_ready;
  logic act_ce, wt_ce, bias_ce;
  logic [AW_A-1:0] act_addr;
  logic [AW_W-1:0] wt_addr;
  logic [AW_O-1:0] bias_addr;
  logic [DW-1:0] act_q = '0, wt_q = '0, bias_q = '0;
  logic [DW-1:0] mul_a, mul_b, out_data;
  logic [2*DW-1:0] mul_p;
  logic [AW_O-1:0] out_idx;
  logic out_valid, out_ready;

  logic [DW-1:0] act_mem [0:N_IN-1];
  logic [DW-1:0] wt_mem [0:N_IN*N_OUT-1];
  logic [DW-1:0] bias_mem [0:N_OUT-1];

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  layer4_fc_mac_sched #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC), .ACC_W(ACC_W),
    .AW_A(AW_A), .AW_W(AW_W), .AW_O(AW_O)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_idle(ap_idle), .ap_done(ap_done), .ap_ready(ap_ready),
    .act_ce(act_ce), .act_addr(act_addr), .act_q(act_q),
    .wt_ce(wt_ce), .wt_addr(wt_addr), .wt_q(wt_q),
    .bias_ce(bias_ce), .bias_addr(bias_addr), .bias_q(bias_q),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 ap_clk = ~ap_clk;

  // External memories (1-cycle read latency) and the shared combinational multiplier.
  always @(posedge ap_clk) begin
    if (act_ce)  act_q  <= act_mem[act_addr];
    if (wt_ce)   wt_q   <= wt_mem[wt_addr];
    if (bias_ce) bias_q <= bias_mem[bias_addr];
  end
  assign mul_p = $signed(mul_a) * $signed(mul_b);

  always @(negedge ap_clk) if (ap_done) done_cnt++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; leaves the DUT in BIAS for neuron 0.
  task automatic applyStimulus();
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
  endtask

  task automatic waitValid(input string tag, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge ap_clk); #1;
      cyc++;
    end
    if (!out_valid) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  task automatic acceptOutput(input string tag, input logic [15:0] ed, input logic [31:0] ei);
    int c;
    waitValid(tag, c);
    checkOutput({tag, "_data"}, out_data, ed);
    checkOutput({tag, "_idx"}, out_idx, ei);
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic finishPass(input string tag);
    checkOutput({tag, "_done"}, ap_done, 1);
    checkOutput({tag, "_ready"}, ap_ready, 1);
    @(posedge ap_clk); #1;
    checkOutput({tag, "_idle"}, ap_idle, 1);
  endtask

  task automatic loadPatternD();
    act_mem  = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    wt_mem   = '{16'h0100, 16'h0100, 16'h0100, 16'h0100,
                 16'h0100, 16'hFF00, 16'h0100, 16'hFF00};
    bias_mem = '{16'h0000, 16'h0040};
  endtask

  initial begin
    int c;
    int d0;
    ap_rst_n  = 1'b0;
    ap_start  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    checkOutput("rst_idle", ap_idle, 1);
    checkOutput("rst_done", ap_done, 0);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_ce", {act_ce, wt_ce, bias_ce}, 0);
    checkOutput("rst_data", out_data, 0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // Unit products, zero bias: each neuron sums four 1.0*1.0 terms.
    act_mem  = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    wt_mem   = '{16'h0100, 16'h0100, 16'h0100, 16'h0100,
                 16'h0100, 16'h0100, 16'h0100, 16'h0100};
    bias_mem = '{16'h0000, 16'h0000};
    d0 = done_cnt;
    applyStimulus();
    checkOutput("a_bias_ce", bias_ce, 1);
    checkOutput("a_issue0", {act_ce, wt_ce}, 2'b11);
    checkOutput("a_wt_addr0", wt_addr, 0);
    @(posedge ap_clk); #1;
    checkOutput("a_act_addr1", act_addr, 1);
    waitValid("a_lat", c);
    checkOutput("a_latency", c + 2, 7);
    acceptOutput("a_n0", 16'h0400, 0);
    checkOutput("a_n1_wt_base", wt_addr, 4);
    checkOutput("a_n1_bias_addr", bias_addr, 1);
    acceptOutput("a_n1", 16'h0400, 1);
    finishPass("a");
    checkOutput("a_done_pulses", done_cnt - d0, 1);

    // Bias alignment, including a negative bias.
    act_mem  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    wt_mem   = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    bias_mem = '{16'h0080, 16'hFF00};
    applyStimulus();
    acceptOutput("b_n0", 16'h0080, 0);
    acceptOutput("b_n1", EXP_NEG_B, 1);
    finishPass("b");

    // Positive and negative saturation.
    act_mem  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    wt_mem   = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                 16'h8001, 16'h8001, 16'h8001, 16'h8001};
    bias_mem = '{16'h0000, 16'h0000};
    applyStimulus();
    acceptOutput("c_n0", 16'h7FFF, 0);
    acceptOutput("c_n1", EXP_NEG_C, 1);
    finishPass("c");

    // Backpressure on neuron 0: output held, no fetches while stalled.
    loadPatternD();
    applyStimulus();
    waitValid("d_wait", c);
    for (int k = 0; k < 5; k++) begin
      @(posedge ap_clk); #1;
      checkOutput("d_stall_valid", out_valid, 1);
      checkOutput("d_stall_data", out_data, 16'h0A00);
      checkOutput("d_stall_issue", {act_ce, wt_ce, bias_ce}, 0);
    end
    acceptOutput("d_n0", 16'h0A00, 0);
    acceptOutput("d_n1", EXP_NEG_D, 1);
    finishPass("d");

    // Asynchronous reset in the middle of neuron 1, then a clean pass.
    applyStimulus();
    acceptOutput("e_n0", 16'h0A00, 0);
    @(posedge ap_clk); #1;
    checkOutput("e_in_mac", act_ce, 1);
    ap_rst_n = 1'b0;
    #1;
    checkOutput("e_rst_idle", ap_idle, 1);
    checkOutput("e_rst_ce", {act_ce, wt_ce, bias_ce}, 0);
    checkOutput("e_rst_mul", mul_a, 0);
    checkOutput("e_rst_valid", out_valid, 0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    applyStimulus();
    acceptOutput("e_n0b", 16'h0A00, 0);
    acceptOutput("e_n1b", EXP_NEG_D, 1);
    finishPass("e");

    // ap_start pulsed mid-pass is ignored; exactly one done pulse.
    d0 = done_cnt;
    applyStimulus();
    @(posedge ap_clk); #1;
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    acceptOutput("f_n0", 16'h0A00, 0);
    acceptOutput("f_n1", EXP_NEG_D, 1);
    finishPass("f");
    repeat (10) @(posedge ap_clk);
    #1;
    checkOutput("f_still_idle", ap_idle, 1);
    checkOutput("f_done_pulses", done_cnt - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
